systolic_scheduler: RTL and testbench

Parametrised control sequencer for the weight-stationary systolic array. It replaces the fixed single-pass scheduler with a start/busy handshake and a programmable cycles-per-stage. It runs one-hot row-by-row weight loading, a skewed fill-and-drain `enable_mult` wavefront, multi-tile repetition and abort. It sits between the host/control register block and the PE array row controls.

---
 rtl/systolic_scheduler.sv | 173 +++++++++++++++++
 tb/tb_systolic_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/systolic_scheduler.sv
// Control sequencer for a weight-stationary systolic array: one-hot row weight
// loading, skewed fill-and-drain multiply wavefront, multi-tile repeat and abort.
module systolic_scheduler #(
  parameter int MATRIX_SIZE  = 2,
  parameter int STAGE_CYCLES = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   general_enable,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_WIDTH-1:0]   num_tiles,
  output logic [MATRIX_SIZE-1:0] load_weight,
  output logic [MATRIX_SIZE-1:0] enable_mult,
  output logic                   busy,
  output logic                   tile_done,
  output logic                   done
);

  localparam int N      = MATRIX_SIZE;
  localparam int S      = STAGE_CYCLES;
  localparam int NSTAGE = 2 * N - 1;
  localparam int KW     = $clog2(N + 1);
  localparam int SW     = $clog2(NSTAGE + 1);
  localparam int CW     = $clog2(S + 1);

  localparam logic [KW-1:0]        K_LAST  = KW'(N - 1);
  localparam logic [SW-1:0]        S_LAST  = SW'(NSTAGE - 1);
  localparam logic [CW-1:0]        C_LAST  = CW'(S - 1);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [N-1:0]         ROW0_LW = N'(1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [SW-1:0]        s_q, s_d;
  logic [CW-1:0]        c_q, c_d;
  logic [CNT_WIDTH-1:0] tiles_q, tiles_d;
  logic [N-1:0]         load_weight_q, load_weight_d;
  logic [N-1:0]         enable_mult_q, enable_mult_d;
  logic                 busy_q, busy_d;
  logic                 tile_done_q, tile_done_d;
  logic                 done_q, done_d;

  // Row j = N-1-i is active for stages j..j+N-1; the MSB row leads the wavefront.
  function automatic logic [N-1:0] wavefront(input logic [SW-1:0] stage);
    logic [N-1:0] wf;
    wf = '0;
    for (int i = 0; i < N; i++) begin
      wf[i] = (int'(stage) >= N - 1 - i) && (int'(stage) <= 2 * N - 2 - i);
    end
    return wf;
  endfunction

  always_comb begin
    // NOTE: every _d defaults to its _q so a frozen cycle holds all state and no latch is inferred.
    state_d       = state_q;
    k_d           = k_q;
    s_d           = s_q;
    c_d           = c_q;
    tiles_d       = tiles_q;
    load_weight_d = load_weight_q;
    enable_mult_d = enable_mult_q;
    busy_d        = busy_q;
    tile_done_d   = tile_done_q;
    done_d        = done_q;

    if (general_enable) begin
      // Outputs are derived from the next state so they register alongside it.
      load_weight_d = '0;
      enable_mult_d = '0;
      busy_d        = 1'b0;
      tile_done_d   = 1'b0;
      done_d        = 1'b0;

      if (busy_q && abort) begin
        state_d = IDLE;
        k_d     = '0;
        s_d     = '0;
        c_d     = '0;
        tiles_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_d       = LOAD;
              k_d           = '0;
              tiles_d       = (num_tiles == '0) ? ONE : num_tiles;
              load_weight_d = ROW0_LW;
              busy_d        = 1'b1;
            end
          end
          LOAD: begin
            busy_d = 1'b1;
            if (k_q == K_LAST) begin
              state_d = COMPUTE;
              s_d     = '0;
              c_d     = '0;
            end else begin
              k_d           = k_q + 1'b1;
              load_weight_d = ROW0_LW << k_d;
            end
          end
          COMPUTE: begin
            busy_d = 1'b1;
            if (c_q != C_LAST) begin
              c_d = c_q + 1'b1;
            end else if (s_q != S_LAST) begin
              s_d = s_q + 1'b1;
              c_d = '0;
            end else begin
              s_d = '0;
              c_d = '0;
              if (tiles_q > ONE) begin
                tiles_d       = tiles_q - ONE;
                state_d       = LOAD;
                k_d           = '0;
                load_weight_d = ROW0_LW;
              end else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end
          end
          DONE: begin
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase

        if (state_d == COMPUTE) begin
          enable_mult_d = wavefront(s_d);
          tile_done_d   = (s_d == S_LAST) && (c_d == C_LAST);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      s_q           <= '0;
      c_q           <= '0;
      tiles_q       <= '0;
      load_weight_q <= '0;
      enable_mult_q <= '0;
      busy_q        <= 1'b0;
      tile_done_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      s_q           <= s_d;
      c_q           <= c_d;
      tiles_q       <= tiles_d;
      load_weight_q <= load_weight_d;
      enable_mult_q <= enable_mult_d;
      busy_q        <= busy_d;
      tile_done_q   <= tile_done_d;
      done_q        <= done_d;
    end
  end

  assign load_weight = load_weight_q;
  assign enable_mult = enable_mult_q;
  assign busy        = busy_q;
  assign tile_done   = tile_done_q;
  assign done        = done_q;

endmodule

// File: tb/tb_systolic_scheduler.sv
// Scoreboard bench for systolic_scheduler: two instances (N=2,S=4 and N=3,S=2);
// expected per-cycle output vectors are queued from the timing formulas at start.
module tb_systolic_scheduler;

  // Packed as {load_weight[2:0], enable_mult[2:0], busy, tile_done, done}
  typedef logic [8:0] vec_t;
  typedef vec_t vq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, general_enable, abort, start_a, start_b;
  logic [7:0] num_tiles;
  logic [1:0] lw_a, em_a;
  logic       busy_a, td_a, done_a;
  logic [2:0] lw_b, em_b;
  logic       busy_b, td_b, done_b;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  string scen  = "init";
  vec_t  sb_q[2][$];
  vec_t  last_exp[2];

  systolic_scheduler #(.MATRIX_SIZE(2), .STAGE_CYCLES(4), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .reset(reset), .general_enable(general_enable), .start(start_a),
    .abort(abort), .num_tiles(num_tiles), .load_weight(lw_a), .enable_mult(em_a),
    .busy(busy_a), .tile_done(td_a), .done(done_a)
  );

  systolic_scheduler #(.MATRIX_SIZE(3), .STAGE_CYCLES(2), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .reset(reset), .general_enable(general_enable), .start(start_b),
    .abort(abort), .num_tiles(num_tiles), .load_weight(lw_b), .enable_mult(em_b),
    .busy(busy_b), .tile_done(td_b), .done(done_b)
  );

  task automatic check(input string tag, input vec_t act, input vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h expected %03h", tag, act, exp);
    end
  endtask

  // Cycle k after the accepting edge; each tile is N+(2N-1)S cycles, then one done cycle.
  function automatic vq_t make_job(input int n, input int s, input int t);
    vq_t  q;
    int   p, u, st;
    vec_t v;
    p = n + (2 * n - 1) * s;
    for (int k = 1; k <= t * p + 1; k++) begin
      v = '0;
      v[2] = 1'b1;
      if (k == t * p + 1) begin
        v[0] = 1'b1;
      end else begin
        u    = (k - 1) % p;
        v[1] = (u == p - 1);
        if (u < n) begin
          v[6 + u] = 1'b1;
        end else begin
          st = (u - n) / s;
          for (int i = 0; i < n; i++)
            if (st >= n - 1 - i && st <= 2 * n - 2 - i) v[3 + i] = 1'b1;
        end
      end
      q.push_back(v);
    end
    return q;
  endfunction

  task automatic step();
    logic r, g, ab;
    logic st[2];
    int   nt;
    vec_t act[2];
    vec_t e;
    r     = reset;
    g     = general_enable;
    ab    = abort;
    st[0] = start_a;
    st[1] = start_b;
    nt    = (num_tiles == 0) ? 1 : int'(num_tiles);
    @(posedge clk);
    #1;
    cyc++;
    act[0] = {1'b0, lw_a, 1'b0, em_a, busy_a, td_a, done_a};
    act[1] = {lw_b, em_b, busy_b, td_b, done_b};
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        sb_q[d].delete();
        e = '0;
      end else if (!g) begin
        e = last_exp[d];
      end else begin
        if (ab && last_exp[d][2]) sb_q[d].delete();
        else if (st[d] && !last_exp[d][2])
          sb_q[d] = make_job((d == 0) ? 2 : 3, (d == 0) ? 4 : 2, nt);
        e = (sb_q[d].size() > 0) ? sb_q[d].pop_front() : '0;
      end
      last_exp[d] = e;
      check($sformatf("%s/%s c%0d", scen, (d == 0) ? "a" : "b", cyc), act[d], e);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    last_exp[0] = '0;
    last_exp[1] = '0;
    reset = 1'b1; general_enable = 1'b1; abort = 1'b0;
    start_a = 1'b0; start_b = 1'b0; num_tiles = 8'd1;
    scen = "reset";
    run(2);
    reset = 1'b0;
    step();

    scen = "single";
    start_a = 1'b1; step(); start_a = 1'b0; run(17);

    scen = "ignore_start";
    start_a = 1'b1; step(); start_a = 1'b0; run(4);
    start_a = 1'b1; num_tiles = 8'd5; step(); start_a = 1'b0; run(12);
    num_tiles = 8'd1;

    scen = "tiles0";
    num_tiles = 8'd0; start_a = 1'b1; step(); start_a = 1'b0; run(17);

    scen = "three_tiles";
    num_tiles = 8'd3; start_b = 1'b1; step(); start_b = 1'b0; run(42);
    num_tiles = 8'd1;

    scen = "back_to_back";
    start_a = 1'b1; step(); start_a = 1'b0; run(14);
    start_a = 1'b1; run(2); start_a = 1'b0; run(17);

    scen = "freeze";
    start_a = 1'b1; step(); start_a = 1'b0; run(4);
    general_enable = 1'b0; run(3);
    general_enable = 1'b1; run(13);

    scen = "freeze_done";
    start_a = 1'b1; step(); start_a = 1'b0; run(14);
    general_enable = 1'b0; run(2);
    general_enable = 1'b1; run(2);

    scen = "abort";
    start_a = 1'b1; step(); start_a = 1'b0; run(8);
    abort = 1'b1; step(); abort = 1'b0;
    start_a = 1'b1; step(); start_a = 1'b0; run(17);

    scen = "abort_tile_done";
    start_a = 1'b1; step(); start_a = 1'b0; run(12);
    abort = 1'b1; step(); abort = 1'b0; run(2);

    scen = "reset_frozen";
    num_tiles = 8'd2; start_b = 1'b1; step(); start_b = 1'b0; run(7);
    reset = 1'b1; general_enable = 1'b0; step();
    reset = 1'b0; general_enable = 1'b1; run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
